// File: rtl/i2s_master_ctrl.sv
// Master-mode I2S clock generator and start/prime/run/drain sequencer for i2s_trx.
// Define I2S_CTRL_PRIME_EN to add the PRIME state that discards the first frame after start.

module i2s_master_ctrl #(
    parameter int unsigned sample_size = 16,
    parameter int unsigned slot_bits   = 32
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] bclk_div,
    input  logic       rx_valid,
    input  logic       sample_ack,
    input  logic       clr_status,
    output logic       bclk,
    output logic       lrclk,
    output logic       trx_enable,
    output logic       trx_reset,
    output logic       running,
    output logic       frame_start,
    output logic       sample_ready,
    output logic       overrun
);

    localparam int unsigned   BW       = $clog2(2 * slot_bits);
    localparam logic [BW-1:0] LAST_BIT = BW'(2 * slot_bits - 1);
    localparam logic [BW-1:0] HALF_BIT = BW'(slot_bits);

    if (sample_size > slot_bits) begin : g_cfg_check
        $error("sample_size must not exceed slot_bits");
    end

    typedef enum logic [2:0] {
        IDLE,
        RST,
        PRIME,
        RUN,
        DRAIN
    } state_t;

    state_t        state, state_next;
    logic [1:0]    rctr;
    logic [7:0]    div;
    logic [7:0]    dctr;
    logic [BW-1:0] bctr;
    logic [BW-1:0] bctr_next;
    logic          rx_valid_q;
    logic          rx_edge;
    logic          hs_edge;
    logic          fall_tick;
    logic          frame_end;
    logic          clk_active_next;
    logic          ovr_set;

    always_comb begin
        rx_edge   = rx_valid && !rx_valid_q;
        fall_tick = (dctr == div) && bclk;
        frame_end = running && fall_tick && (bctr == LAST_BIT);
        bctr_next = (bctr == LAST_BIT) ? '0 : bctr + 1'b1;
        hs_edge   = rx_edge && ((state == RUN) || (state == DRAIN));
        ovr_set   = hs_edge && sample_ready && !sample_ack;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RST;
                end
            end
            RST: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (rctr == 2'd3) begin
`ifdef I2S_CTRL_PRIME_EN
                    state_next = PRIME;
`else
                    state_next = RUN;
`endif
                end
            end
            PRIME: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (rx_edge) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        trx_reset       = (state == IDLE) || (state == RST);
        running         = (state == PRIME) || (state == RUN) || (state == DRAIN);
        trx_enable      = running;
        clk_active_next = (state_next == PRIME) || (state_next == RUN) || (state_next == DRAIN);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rctr <= '0;
            div  <= '0;
        end else begin
            rctr <= (state == RST) ? rctr + 1'b1 : '0;
            if ((state == IDLE) && start && !stop) begin
                div <= (bclk_div == '0) ? 8'd1 : bclk_div;
            end
        end
    end

    // Leaving the clocking states (drain end or abort) parks the clocks low in the same edge.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            dctr  <= '0;
            bctr  <= '0;
            bclk  <= 1'b0;
            lrclk <= 1'b0;
        end else if (!running || !clk_active_next) begin
            dctr  <= '0;
            bctr  <= '0;
            bclk  <= 1'b0;
            lrclk <= 1'b0;
        end else if (dctr == div) begin
            dctr <= '0;
            bclk <= !bclk;
            if (bclk) begin
                bctr  <= bctr_next;
                lrclk <= (bctr_next >= HALF_BIT);
            end
        end else begin
            dctr <= dctr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
        end
    end

    // An edge coinciding with an ack re-arms sample_ready without flagging overrun.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid_q   <= 1'b0;
            sample_ready <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if (hs_edge) begin
                sample_ready <= 1'b1;
            end else if (sample_ack) begin
                sample_ready <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Scoreboard bench for i2s_master_ctrl: planned sessions push expected event cycles, a monitor pops them.
// Honours I2S_CTRL_PRIME_EN the same way the design does.

module tb_i2s_master_ctrl;

    localparam int unsigned SLOT = 32;
`ifdef I2S_CTRL_PRIME_EN
    localparam bit PRIME_EN = 1'b1;
`else
    localparam bit PRIME_EN = 1'b0;
`endif

    logic       sys_clk    = 1'b0;
    logic       reset_n    = 1'b1;
    logic       start      = 1'b0;
    logic       stop       = 1'b0;
    logic [7:0] bclk_div   = 8'd1;
    logic       rx_valid   = 1'b0;
    logic       sample_ack = 1'b0;
    logic       clr_status = 1'b0;
    logic       bclk, lrclk, trx_enable, trx_reset, running, frame_start, sample_ready, overrun;

    i2s_master_ctrl #(.sample_size(16), .slot_bits(SLOT)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .stop(stop),
        .bclk_div(bclk_div), .rx_valid(rx_valid), .sample_ack(sample_ack),
        .clr_status(clr_status), .bclk(bclk), .lrclk(lrclk), .trx_enable(trx_enable),
        .trx_reset(trx_reset), .running(running), .frame_start(frame_start),
        .sample_ready(sample_ready), .overrun(overrun)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    int unsigned tests = 0, fails = 0;
    int unsigned exp_fs[$], exp_sr[$], exp_ovr[$], exp_stop[$];
    int unsigned run_lo = 1, run_hi = 0, w_half = 1, w_fp = 2;
    int unsigned wave_err = 0;
    bit          mon_en = 1'b0, ack_en = 1'b1, sr_model = 1'b0, ovr_model = 1'b0;
    logic        e_run, e_bclk, e_lr, prev_sr = 1'b0, prev_ovr = 1'b0, prev_run = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: reference waveform from session arithmetic plus event scoreboard.
    initial forever begin
        @(negedge sys_clk);
        if (mon_en) begin
            e_run  = (cyc >= run_lo) && (cyc <= run_hi);
            e_bclk = e_run && ((((cyc - run_lo) / w_half) % 2) == 1);
            e_lr   = e_run && ((((cyc - run_lo) / (w_fp / 2)) % 2) == 1);
            if ({running, trx_enable, trx_reset, bclk, lrclk} != {e_run, e_run, !e_run, e_bclk, e_lr})
                wave_err++;
            if (frame_start)
                check("frame_start_cycle", cyc, exp_fs.size() != 0 ? exp_fs.pop_front() : 0);
            if (sample_ready && !prev_sr)
                check("sample_ready_cycle", cyc, exp_sr.size() != 0 ? exp_sr.pop_front() : 0);
            if (overrun && !prev_ovr)
                check("overrun_cycle", cyc, exp_ovr.size() != 0 ? exp_ovr.pop_front() : 0);
            if (!running && prev_run)
                check("drain_end_cycle", cyc, exp_stop.size() != 0 ? exp_stop.pop_front() : 0);
        end
        prev_sr  = sample_ready;
        prev_ovr = overrun;
        prev_run = running;
    end

    // Consumer: acknowledges each new sample within about 10 cycles when enabled.
    initial forever begin
        @(negedge sys_clk);
        if (sample_ready && ack_en) begin
            repeat ($urandom_range(0, 8)) @(posedge sys_clk);
            @(posedge sys_clk);
            #1 sample_ack = 1'b1;
            @(posedge sys_clk);
            #1 sample_ack = 1'b0;
        end
    end

    task automatic run_session(input logic [7:0] dv, input int unsigned extra_edges,
                               input int unsigned stop_rel, input bit ack_on, input string tag);
        int unsigned p, h, fp, e, s, n, x, base;
        int unsigned ec[$];
        bit          first;
        p    = cyc;
        h    = ((dv == 8'd0) ? 1 : int'(dv)) + 1;
        fp   = 4 * SLOT * h;
        e    = p + 5;
        s    = e + stop_rel;
        n    = (s + 2 - e + fp - 1) / fp;
        x    = e + n * fp;
        base = wave_err;
        for (int unsigned k = 1; k <= n; k++) exp_fs.push_back(e + k * fp);
        exp_stop.push_back(x);
        ec.push_back(e + $urandom_range(20, 60));
        for (int unsigned k = 1; k <= extra_edges; k++) ec.push_back(e + k * fp + $urandom_range(20, 150));
        first = 1'b1;
        foreach (ec[i]) begin
            if (!(PRIME_EN && first)) begin
                if (!sr_model) exp_sr.push_back(ec[i] + 1);
                else if (!ovr_model) begin
                    exp_ovr.push_back(ec[i] + 1);
                    ovr_model = 1'b1;
                end
                sr_model = !ack_on;
            end
            first = 1'b0;
        end
        w_half = h;
        w_fp   = fp;
        run_lo = e;
        run_hi = x - 1;
        ack_en = ack_on;
        for (int unsigned c = p; c <= x + 3; c++) begin
            start    = (c == p);
            stop     = (c == s);
            bclk_div = (c == p) ? dv : 8'($urandom);
            rx_valid = 1'b0;
            foreach (ec[i]) if (c >= ec[i] && c < ec[i] + 8) rx_valid = 1'b1;
            @(posedge sys_clk);
            #1;
        end
        start    = 1'b0;
        stop     = 1'b0;
        rx_valid = 1'b0;
        repeat (15) @(posedge sys_clk);
        #1;
        check({"wave_", tag}, wave_err - base, 0);
        check({"frames_left_", tag}, exp_fs.size(), 0);
        check({"samples_left_", tag}, exp_sr.size(), 0);
    endtask

    task automatic abort_session(input bit in_rst, input string tag);
        int unsigned p, base;
        p      = cyc;
        base   = wave_err;
        run_lo = 1;
        run_hi = 0;
        bclk_div = 8'd2;
        for (int unsigned c = p; c <= p + 30; c++) begin
            start = (c == p);
            stop  = in_rst ? (c == p + 2) : (c == p);
            @(posedge sys_clk);
            #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        check({"wave_", tag}, wave_err - base, 0);
        check({"trx_reset_", tag}, trx_reset, 1);
    endtask

    initial begin
        int unsigned ex, fp, dv;
        #2 reset_n = 1'b0;
        #1;
        check("rst_bclk", bclk, 0);
        check("rst_lrclk", lrclk, 0);
        check("rst_trx_enable", trx_enable, 0);
        check("rst_trx_reset", trx_reset, 1);
        check("rst_running", running, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_sample_ready", sample_ready, 0);
        check("rst_overrun", overrun, 0);
        repeat (3) @(posedge sys_clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1 check("idle_hold_wave", wave_err, 0);

        run_session(8'd1, 3, 4 * 256 - 50, 1'b1, "run_div1");
        check("no_overrun", overrun, 0);

        run_session(8'd1, 2, 3 * 256 - 40, 1'b0, "ovr");
        check("overrun_set", overrun, 1);
        clr_status = 1'b1;
        @(posedge sys_clk);
        #1 clr_status = 1'b0;
        check("overrun_cleared", overrun, 0);
        ovr_model = 1'b0;
        ack_en    = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1 check("ready_acked", sample_ready, 0);
        sr_model = 1'b0;

        run_session(8'd3, 1, 512 + 21 * 4, 1'b1, "drain_div3");
        run_session(8'd0, 0, $urandom_range(100, 200), 1'b1, "clamp_div0");

        abort_session(1'b1, "abort_rst");
        abort_session(1'b0, "start_stop_idle");

        for (int k = 0; k < 2; k++) begin
            dv = $urandom_range(1, 4);
            ex = $urandom_range(0, 2);
            fp = 4 * SLOT * (dv + 1);
            run_session(8'(dv), ex, ex * fp + $urandom_range(160, fp + 100), 1'b1, "random");
        end

        check("stops_left", exp_stop.size(), 0);
        check("overruns_left", exp_ovr.size(), 0);
        check("final_overrun", overrun, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
